// File: rtl/nnz_insp_pipe_if.sv
// Purpose: bundles the beat-in / beat-out handshake and statistics of nnz_insp_pipe.
// Latency: none; this file only declares wires.
// Backpressure: out_ready -> in_ready stall-all handshake carried on these signals.
interface nnz_insp_pipe_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_W-1:0]   offset1;
    logic [LANES*DATA_W-1:0]   offset2;
    logic [LANES*2-1:0]        in_prediction;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*2-1:0]        out_prediction;
    logic [LANES-1:0]          out_lane_valid;
    logic                      flush;
    logic [2:0]                flush_lane;
    logic [CNT_W-1:0]          flush_count;
    logic [CNT_W-1:0]          squash_count;

    // Producer/consumer side of the block (drives beats in, accepts beats out).
    modport master (
        output in_valid, offset1, offset2, in_prediction, out_ready,
        input  in_ready, out_valid, out_prediction, out_lane_valid,
               flush, flush_lane, flush_count, squash_count
    );

    // The inspection pipeline itself.
    modport slave (
        input  in_valid, offset1, offset2, in_prediction, out_ready,
        output in_ready, out_valid, out_prediction, out_lane_valid,
               flush, flush_lane, flush_count, squash_count
    );
endinterface

// File: rtl/nnz_insp_pipe.sv
// Purpose: resolves per-lane sparse-index merge outcomes, flags the first mispredicted lane, squashes wrong-path beats.
// Latency: 2 cycles from input acceptance to out_valid (S1 capture, S2 output).
// Backpressure: stall-all; in_ready = !out_valid || out_ready, both stages hold while stalled.
module nnz_insp_pipe #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst,
    nnz_insp_pipe_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                    en;
    logic                    s1_valid;
    logic [LANES*DATA_W-1:0] s1_off1;
    logic [LANES*DATA_W-1:0] s1_off2;
    logic [LANES*2-1:0]      s1_pred;

    logic [LANES*2-1:0]      res_pred;
    logic [LANES-1:0]        mispred;
    logic                    any_mis;
    logic [2:0]              first_lane;
    logic [LANES-1:0]        lane_mask;
    logic                    moving_flush;

    assign en          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    // A mispredicting beat leaving S1 this edge makes whatever is entering S1 wrong-path.
    assign moving_flush = en && s1_valid && any_mis;

    // Resolve every lane from its offset pair and compare against the prediction.
    always_comb begin
        res_pred = '0;
        mispred  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_off1[i*DATA_W +: DATA_W] == s1_off2[i*DATA_W +: DATA_W]) begin
                res_pred[i*2 +: 2] = 2'b00;
            end else if (s1_off1[i*DATA_W +: DATA_W] < s1_off2[i*DATA_W +: DATA_W]) begin
                res_pred[i*2 +: 2] = 2'b01;
            end else begin
                res_pred[i*2 +: 2] = 2'b10;
            end
            // Resolved outcome is never 11, so a reserved prediction always mismatches.
            mispred[i] = (s1_pred[i*2 +: 2] != res_pred[i*2 +: 2]);
        end
    end

    // Find the lowest mispredicting lane and keep lanes up to and including it.
    always_comb begin
        any_mis    = |mispred;
        first_lane = '0;
        lane_mask  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mispred[i]) begin
                first_lane = 3'(i);
            end
        end
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = !any_mis || (3'(i) <= first_lane);
        end
    end

    // S1: capture the accepted beat, dropping it if it is on the wrong path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_off1  <= '0;
            s1_off2  <= '0;
            s1_pred  <= '0;
        end else if (en) begin
            s1_valid <= bus.in_valid && !(s1_valid && any_mis);
            if (bus.in_valid) begin
                s1_off1 <= bus.offset1;
                s1_off2 <= bus.offset2;
                s1_pred <= bus.in_prediction;
            end
        end
    end

    // S2: load the resolved beat (or a bubble) when the pipe advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.out_prediction <= '0;
            bus.out_lane_valid <= '0;
            bus.flush          <= 1'b0;
            bus.flush_lane     <= '0;
        end else if (en) begin
            bus.out_valid      <= s1_valid;
            bus.out_prediction <= s1_valid ? res_pred : '0;
            bus.out_lane_valid <= s1_valid ? lane_mask : '0;
            bus.flush          <= s1_valid && any_mis;
            bus.flush_lane     <= (s1_valid && any_mis) ? first_lane : 3'd0;
        end
    end

    // Saturating statistics: one flush per flushing S2 load, one squash per discarded input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.flush_count  <= '0;
            bus.squash_count <= '0;
        end else begin
            if (moving_flush && bus.flush_count != CNT_MAX) begin
                bus.flush_count <= bus.flush_count + CNT_ONE;
            end
            if (moving_flush && bus.in_valid && bus.squash_count != CNT_MAX) begin
                bus.squash_count <= bus.squash_count + CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_nnz_insp_pipe.sv
// Purpose: randomized and directed check of nnz_insp_pipe against a beat-level reference model.
// Latency: model predicts outputs 2 cycles after acceptance.
// Backpressure: bench toggles out_ready and compares in_ready every cycle.
module tb_nnz_insp_pipe;
    localparam int DATA_W = 16;
    localparam int LANES  = 4;
    localparam int CNT_W  = 2;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    typedef logic [LANES-1:0][DATA_W-1:0] offs_t;
    typedef logic [LANES-1:0][1:0]        pred_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nnz_insp_pipe_if #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) bus ();
    nnz_insp_pipe #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    offs_t d_o1, d_o2;
    pred_t d_p;
    logic  d_vld, d_ordy;
    assign bus.offset1       = d_o1;
    assign bus.offset2       = d_o2;
    assign bus.in_prediction = d_p;
    assign bus.in_valid      = d_vld;
    assign bus.out_ready     = d_ordy;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] outcome(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (a == b) return 2'b00;
        if (a < b)  return 2'b01;
        return 2'b10;
    endfunction

    // Reference model: one accepted beat waits in the first slot, then is judged and published.
    logic          m_s1_vld;
    offs_t         m_o1, m_o2;
    pred_t         m_p;
    logic          m_ov;
    pred_t         m_opred;
    logic [LANES-1:0] m_olv;
    logic          m_fl;
    logic [2:0]    m_flane;
    logic [CNT_W-1:0] m_fc, m_sc;

    always @(posedge clk or posedge rst) begin : model
        pred_t r;
        int    first;
        logic  en;
        if (rst) begin
            m_s1_vld = 1'b0; m_ov = 1'b0; m_opred = '0; m_olv = '0;
            m_fl = 1'b0; m_flane = '0; m_fc = '0; m_sc = '0;
        end else begin
            en = !m_ov || d_ordy;
            if (en) begin
                first = -1;
                for (int i = 0; i < LANES; i++) begin
                    r[i] = outcome(m_o1[i], m_o2[i]);
                    if (first < 0 && r[i] != m_p[i]) first = i;
                end
                m_ov = m_s1_vld;
                if (m_s1_vld) begin
                    m_opred = r;
                    m_fl    = (first >= 0);
                    m_flane = (first >= 0) ? first[2:0] : 3'd0;
                    m_olv   = (first >= 0) ? LANES'((1 << (first + 1)) - 1) : {LANES{1'b1}};
                    if (first >= 0 && m_fc != CMAX) m_fc = m_fc + 1'b1;
                    if (first >= 0 && d_vld && m_sc != CMAX) m_sc = m_sc + 1'b1;
                end else begin
                    m_opred = '0; m_fl = 1'b0; m_flane = '0; m_olv = '0;
                end
                m_s1_vld = d_vld && !(m_s1_vld && first >= 0);
                if (d_vld) begin
                    m_o1 = d_o1; m_o2 = d_o2; m_p = d_p;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en && !rst) begin
            chk("in_ready", bus.in_ready, !m_ov || d_ordy);
            chk("out_valid", bus.out_valid, m_ov);
            chk("flush", bus.flush, m_fl);
            chk("out_lane_valid", bus.out_lane_valid, m_olv);
            chk("flush_lane", bus.flush_lane, m_flane);
            chk("flush_count", bus.flush_count, m_fc);
            chk("squash_count", bus.squash_count, m_sc);
            if (m_ov) chk("out_prediction", bus.out_prediction, m_opred);
        end
    end

    task automatic set_beat(input offs_t a, input offs_t b, input pred_t p);
        d_o1 = a; d_o2 = b; d_p = p; d_vld = 1'b1;
    endtask

    task automatic rand_beat();
        int roll;
        for (int i = 0; i < LANES; i++) begin
            d_o1[i] = DATA_W'($urandom_range(0, 3));
            d_o2[i] = DATA_W'($urandom_range(0, 3));
            roll = $urandom_range(0, 11);
            if (roll == 0)      d_p[i] = 2'b11;
            else if (roll == 1) d_p[i] = (outcome(d_o1[i], d_o2[i]) == 2'b10) ? 2'b00 : outcome(d_o1[i], d_o2[i]) + 2'b01;
            else                d_p[i] = outcome(d_o1[i], d_o2[i]);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; d_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    offs_t g1, g2, b1, b2;
    pred_t gp, bp;

    initial begin
        rst = 1'b1; d_vld = 1'b0; d_ordy = 1'b1;
        d_o1 = '0; d_o2 = '0; d_p = '0;
        // Good beat: lane0 5/5 match, others 1/9 advance A.
        g1 = '{16'd1, 16'd1, 16'd1, 16'd5};
        g2 = '{16'd9, 16'd9, 16'd9, 16'd5};
        gp = '{2'b01, 2'b01, 2'b01, 2'b00};
        // Bad beat: lane1 9/3 predicted 01 but resolves 10.
        b1 = '{16'd1, 16'd1, 16'd9, 16'd5};
        b2 = '{16'd9, 16'd9, 16'd3, 16'd5};
        bp = '{2'b01, 2'b01, 2'b01, 2'b00};
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_flush", bus.flush, 1'b0);
        chk("rst_counts", {bus.flush_count, bus.squash_count}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // All-correct beat.
        @(negedge clk); set_beat(g1, g2, gp);
        @(negedge clk); d_vld = 1'b0;
        @(negedge clk);
        chk("d_good_valid", bus.out_valid, 1'b1);
        chk("d_good_flush", bus.flush, 1'b0);
        chk("d_good_lanes", bus.out_lane_valid, 4'b1111);

        // Lane1 mispredict.
        set_beat(b1, b2, bp);
        @(negedge clk); d_vld = 1'b0;
        @(negedge clk);
        chk("d_bad_flush", bus.flush, 1'b1);
        chk("d_bad_lane", bus.flush_lane, 3'd1);
        chk("d_bad_lanes", bus.out_lane_valid, 4'b0011);
        chk("d_bad_pred1", bus.out_prediction[3:2], 2'b10);
        chk("d_bad_fcount", bus.flush_count, 2'd1);

        // Back-to-back: bad, then squashed good, then good.
        set_beat(b1, b2, bp);
        @(negedge clk); set_beat(g1, g2, gp);
        @(negedge clk);
        chk("d_sq_in_ready", bus.in_ready, 1'b1);
        set_beat(g1, g2, gp);
        @(negedge clk); d_vld = 1'b0;
        chk("d_sq_bubble", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("d_sq_third", bus.out_valid, 1'b1);
        chk("d_sq_third_flush", bus.flush, 1'b0);
        chk("d_sq_count", bus.squash_count, 2'd1);

        // Output stall with a flushing beat held for three cycles.
        pulse_reset();
        set_beat(b1, b2, bp);
        @(negedge clk); set_beat(g1, g2, gp);
        @(negedge clk); d_ordy = 1'b0; set_beat(g1, g2, gp);
        repeat (3) begin
            @(negedge clk);
            chk("d_stall_in_ready", bus.in_ready, 1'b0);
            chk("d_stall_flush", bus.flush, 1'b1);
            chk("d_stall_fcount", bus.flush_count, 2'd1);
        end
        d_ordy = 1'b1; d_vld = 1'b0;
        repeat (4) @(negedge clk);

        // Saturation: five flushing beats separated by bubbles.
        pulse_reset();
        repeat (5) begin
            set_beat(b1, b2, bp);
            @(negedge clk); d_vld = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        chk("d_sat_fcount", bus.flush_count, 2'd3);

        // Reset with two beats in flight.
        set_beat(g1, g2, gp);
        @(negedge clk); set_beat(b1, b2, bp);
        @(negedge clk); d_vld = 1'b0; rst = 1'b1;
        #1;
        chk("d_rst_valid", bus.out_valid, 1'b0);
        chk("d_rst_counts", {bus.flush_count, bus.squash_count}, '0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);

        // Random traffic with random backpressure and occasional reset.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1; d_vld = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                rand_beat();
                d_vld  = ($urandom_range(0, 3) != 0);
                d_ordy = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk); d_vld = 1'b0; d_ordy = 1'b1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
